// File: rtl/uart_tx_buffered_if.sv
// Byte-push side of the buffered UART transmitter: the core drives wr_data/wr_en,
// the transmitter reports occupancy and the serial line.
interface uart_tx_buffered_if #(
  parameter int FIFO_DEPTH_LOG2 = 3
);
  logic [7:0]               wr_data;
  logic                     wr_en;
  logic                     full;
  logic                     busy;
  logic [FIFO_DEPTH_LOG2:0] count;
  logic                     txd;

  modport master (output wr_data, wr_en, input full, busy, count, txd);
  modport slave  (input wr_data, wr_en, output full, busy, count, txd);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a small circular FIFO feeding a START/DATA/STOP
// serialiser. full is the core's stall; txd is a registered, idle-high line.
module uart_tx_buffered #(
  parameter int CLK_PER_HALF_BIT = 520,
  parameter int FIFO_DEPTH_LOG2  = 3
) (
  input logic          clk,
  input logic          rstn,
  uart_tx_buffered_if.slave bus
);
  localparam int DEPTH    = 2 ** FIFO_DEPTH_LOG2;
  localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
  localparam int BAUD_W   = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
  localparam int CNT_W    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                     state;
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [CNT_W-1:0]           count;
  logic [7:0]                 shift;
  logic [2:0]                 bit_idx;
  logic [BAUD_W-1:0]          baud;
  logic                       txd_q;
  logic                       push;
  logic                       pop;
  logic                       bit_done;

  assign bit_done = (baud == BAUD_LAST);
  // full comes from the registered count, so a same-cycle pop never frees room for this write
  assign push     = bus.wr_en & (count != DEPTH_CNT);
  assign pop      = (count != '0) & ((state == IDLE) | ((state == STOP) & bit_done));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
      if (push & ~pop)      count <= count + CNT_W'(1);
      else if (pop & ~push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  // txd reflects the state held during the previous cycle, so every bit is
  // exactly one bit period on the line and frames chain with no gap.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd_q <= 1'b1;
          baud  <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
          end
        end
        START: begin
          txd_q <= 1'b0;
          if (bit_done) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        DATA: begin
          txd_q <= shift[0];
          if (bit_done) begin
            baud  <= '0;
            shift <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        STOP: begin
          txd_q <= 1'b1;
          if (bit_done) begin
            baud <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.full  = (count == DEPTH_CNT);
  assign bus.count = count;
  assign bus.busy  = (state != IDLE) | (count != '0);
  assign bus.txd   = txd_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: cycle-exact txd frame checks, a FIFO fill
// table, and a line monitor that decodes transmitted bytes.
module tb_uart_tx_buffered;
  localparam int HB   = 4;
  localparam int LOG2 = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_tx_buffered_if #(.FIFO_DEPTH_LOG2(LOG2)) bus ();

  uart_tx_buffered #(.CLK_PER_HALF_BIT(HB), .FIFO_DEPTH_LOG2(LOG2)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] rx_q[$];
  int rst_cnt = 0;

  typedef struct {
    logic       wr_en;
    logic [7:0] data;
    logic [3:0] count;
    logic       full;
    logic       txd;
  } vec_t;
  vec_t vt[13];

  always @(posedge clk) if (!rstn) rst_cnt <= rst_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Bit k (0..79) of the line waveform for one frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k < 8) return 1'b0;
    if (k < 72) return b[(k - 8) / 8];
    return 1'b1;
  endfunction

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (bus.busy && n < limit) begin
      tick();
      n++;
    end
    check(name, 32'(n >= limit), 32'd0);
    repeat (4) tick();
  endtask

  // Line monitor: mid-bit sampling, frames cut by a reset are discarded.
  initial begin
    logic [7:0] b;
    logic       prev;
    int         rc;
    prev = 1'b1;
    b = '0;
    forever begin
      @(negedge clk);
      if (rstn && prev && !bus.txd) begin
        rc = rst_cnt;
        repeat (HB) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (2 * HB) @(negedge clk);
          b[j] = bus.txd;
        end
        repeat (2 * HB) @(negedge clk);
        if (rc == rst_cnt && bus.txd === 1'b1) rx_q.push_back(b);
      end
      prev = bus.txd;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    int busy_bad;
    int n;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    rstn        = 1'b0;

    // Reset and idle line
    repeat (3) tick();
    check("rst_txd", 32'(bus.txd), 32'd1);
    check("rst_count", 32'(bus.count), 32'd0);
    rstn = 1'b1;
    tick();
    check("rel_full", 32'(bus.full), 32'd0);
    check("rel_busy", 32'(bus.busy), 32'd0);
    bad = 0;
    repeat (100) begin
      tick();
      if (bus.txd !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    check("idle_100", 32'(bad), 32'd0);

    // Single byte 0x55, cycle-exact waveform
    rx_q.delete();
    bus.wr_data = 8'h55;
    bus.wr_en   = 1'b1;
    tick();
    check("t2_count_after_push", 32'(bus.count), 32'd1);
    bus.wr_en = 1'b0;
    tick();
    check("t2_count_after_pop", 32'(bus.count), 32'd0);
    check("t2_txd_pop_cycle", 32'(bus.txd), 32'd1);
    bad = 0;
    busy_bad = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (bus.txd !== frame_bit(8'h55, k)) bad++;
      if (k < 79 && bus.busy !== 1'b1) busy_bad++;
    end
    check("t2_frame_55", 32'(bad), 32'd0);
    check("t2_busy_during_frame", 32'(busy_bad), 32'd0);
    check("t2_busy_drop", 32'(bus.busy), 32'd0);
    repeat (4) tick();
    check("t2_rx_size", 32'(rx_q.size()), 32'd1);
    check("t2_rx_byte", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hdead, 32'h55);

    // FIFO fill: wr_en held 12 cycles with data 0x10+i
    for (int i = 0; i < 12; i++) begin
      vt[i].wr_en = 1'b1;
      vt[i].data  = 8'(8'h10 + i);
      vt[i].count = (i < 8) ? ((i == 0) ? 4'd1 : 4'(i)) : 4'd8;
      vt[i].full  = (i >= 8);
      vt[i].txd   = (i < 2);
    end
    vt[12] = '{wr_en: 1'b0, data: 8'h00, count: 4'd8, full: 1'b1, txd: 1'b0};
    rx_q.delete();
    for (int i = 0; i < 13; i++) begin
      bus.wr_en   = vt[i].wr_en;
      bus.wr_data = vt[i].data;
      tick();
      check($sformatf("t3_count[%0d]", i), 32'(bus.count), 32'(vt[i].count));
      check($sformatf("t3_full[%0d]", i), 32'(bus.full), 32'(vt[i].full));
      check($sformatf("t3_txd[%0d]", i), 32'(bus.txd), 32'(vt[i].txd));
    end
    bus.wr_en = 1'b0;
    wait_idle(1200, "t3_timeout");
    check("t3_rx_size", 32'(rx_q.size()), 32'd9);
    for (int i = 0; i < 9; i++)
      check($sformatf("t3_rx[%0d]", i), (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hdead, 32'(8'h10 + i));

    // Back-to-back frames 0xA5, 0x3C
    rx_q.delete();
    bus.wr_data = 8'hA5;
    bus.wr_en   = 1'b1;
    tick();
    bus.wr_data = 8'h3C;
    tick();
    bus.wr_en = 1'b0;
    bad = 0;
    for (int k = 0; k < 160; k++) begin
      tick();
      if (bus.txd !== frame_bit((k < 80) ? 8'hA5 : 8'h3C, k % 80)) bad++;
    end
    check("t4_two_frames", 32'(bad), 32'd0);
    check("t4_busy_end", 32'(bus.busy), 32'd0);
    repeat (4) tick();
    check("t4_rx_size", 32'(rx_q.size()), 32'd2);
    check("t4_rx1", (rx_q.size() > 1) ? 32'(rx_q[1]) : 32'hdead, 32'h3C);

    // Reset during data bit 3 with 4 bytes queued
    rx_q.delete();
    for (int i = 0; i < 5; i++) begin
      bus.wr_data = 8'(8'h81 + i);
      bus.wr_en   = 1'b1;
      tick();
    end
    bus.wr_en = 1'b0;
    repeat (31) tick();
    check("t5_count_before", 32'(bus.count), 32'd4);
    check("t5_txd_bit3", 32'(bus.txd), 32'd0);
    rstn = 1'b0;
    tick();
    check("t5_txd", 32'(bus.txd), 32'd1);
    check("t5_count", 32'(bus.count), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    rstn = 1'b1;
    bad = 0;
    repeat (200) begin
      tick();
      if (bus.txd !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    check("t5_quiet", 32'(bad), 32'd0);
    check("t5_rx_none", 32'(rx_q.size()), 32'd0);

    // Full FIFO with a pop at end of STOP while writing
    rx_q.delete();
    for (int i = 0; i < 9; i++) begin
      bus.wr_data = 8'(8'h60 + i);
      bus.wr_en   = 1'b1;
      tick();
    end
    bus.wr_en = 1'b0;
    check("t6_full_set", 32'(bus.full), 32'd1);
    repeat (72) tick();
    check("t6_count_pre_pop", 32'(bus.count), 32'd8);
    check("t6_full_pre_pop", 32'(bus.full), 32'd1);
    bus.wr_data = 8'hEE;
    bus.wr_en   = 1'b1;
    tick();
    check("t6_count_after_pop", 32'(bus.count), 32'd7);
    check("t6_full_after_pop", 32'(bus.full), 32'd0);
    bus.wr_data = 8'hEF;
    tick();
    bus.wr_en = 1'b0;
    check("t6_count_refill", 32'(bus.count), 32'd8);
    wait_idle(1200, "t6_timeout");
    check("t6_rx_size", 32'(rx_q.size()), 32'd10);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] e;
      e = (i < 9) ? 8'(8'h60 + i) : 8'hEF;
      if (i >= rx_q.size() || rx_q[i] !== e) n++;
    end
    check("t6_rx_stream", 32'(n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
